// File: rtl/vga_vram_scanner.sv
`default_nettype none
// ============================================================================
// Module   : vga_vram_scanner
// Purpose  : 640x480@60 VGA timing generator and VRAM scanner. Drives the
//            shared 14-bit read address of three 1-bit VRAM ROMs (one-clock
//            read latency), upscales the 128x96 stored image by SCALE in both
//            axes, and produces aligned active-low syncs and 4-bit colours.
// Ports    : clk          in   system clock (also clocks the VRAMs)
//            reset        in   synchronous, active-high reset
//            vram_addr    out  [13:0] read address = {row[6:0], col[6:0]}
//            vram_r/g/b   in   1-bit VRAM data, one clk after the address
//            hsync/vsync  out  active-low syncs
//            vga_r/g/b    out  [3:0] colour outputs
//            frame_start  out  one-clk pulse as output pixel (0,0) appears
// Options  : define VGA_TEST_PATTERN_EN to replace VRAM colour with a
//            checkerboard of 8x8 stored-pixel squares (address still runs).
// Revision : 1.0  initial release
// ============================================================================
module vga_vram_scanner #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic [13:0] vram_addr,
    input  logic        vram_r,
    input  logic        vram_g,
    input  logic        vram_b,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DW      = $clog2(CLK_DIV);
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int c_COLS    = (c_H_TOTAL + SCALE - 1) / SCALE;
    localparam int c_ROWS    = (c_V_TOTAL + SCALE - 1) / SCALE;
    // col/row keep running through blanking, so they may need more than the
    // 7 bits that reach the address; never narrower than 7.
    localparam int c_CW      = ($clog2(c_COLS) > 7) ? $clog2(c_COLS) : 7;
    localparam int c_RW      = ($clog2(c_ROWS) > 7) ? $clog2(c_ROWS) : 7;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_FIRST = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_LAST  = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_FIRST = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_LAST  = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [c_SW-1:0] c_SUB_LAST = c_SW'(SCALE - 1);

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic [c_DW-1:0] r_div;
    logic            w_tick;

    assign w_tick = (r_div == c_DIV_LAST);

    // ------------------------------------------------------------------
    // Stage-0 counters and their next-state values
    // ------------------------------------------------------------------
    logic [c_HW-1:0] r_hcnt, w_hcnt_nxt;
    logic [c_VW-1:0] r_vcnt, w_vcnt_nxt;
    logic [c_SW-1:0] r_hsub, w_hsub_nxt;
    logic [c_SW-1:0] r_vsub, w_vsub_nxt;
    logic [c_CW-1:0] r_col,  w_col_nxt;
    logic [c_RW-1:0] r_row,  w_row_nxt;
    logic            w_h_wrap, w_v_wrap, w_hsub_wrap, w_vsub_wrap;
    logic            w_active_nxt;

    always_comb begin
        w_h_wrap    = (r_hcnt == c_H_LAST);
        w_v_wrap    = (r_vcnt == c_V_LAST);
        w_hsub_wrap = (r_hsub == c_SUB_LAST);
        w_vsub_wrap = (r_vsub == c_SUB_LAST);

        w_hcnt_nxt  = w_h_wrap ? '0 : r_hcnt + 1'b1;
        w_hsub_nxt  = (w_h_wrap || w_hsub_wrap) ? '0 : r_hsub + 1'b1;
        w_col_nxt   = w_h_wrap ? '0 : (w_hsub_wrap ? r_col + 1'b1 : r_col);

        w_vcnt_nxt  = r_vcnt;
        w_vsub_nxt  = r_vsub;
        w_row_nxt   = r_row;
        if (w_h_wrap) begin
            w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + 1'b1;
            w_vsub_nxt = (w_v_wrap || w_vsub_wrap) ? '0 : r_vsub + 1'b1;
            w_row_nxt  = w_v_wrap ? '0 : (w_vsub_wrap ? r_row + 1'b1 : r_row);
        end

        w_active_nxt = (w_hcnt_nxt < c_H_ACT) && (w_vcnt_nxt < c_V_ACT);
    end

    // ------------------------------------------------------------------
    // Stage-0 decode of the current pixel
    // ------------------------------------------------------------------
    logic w_active, w_hs_n, w_vs_n;
    logic w_pix_r, w_pix_g, w_pix_b;

    assign w_active = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign w_hs_n   = !((r_hcnt >= c_HS_FIRST) && (r_hcnt <= c_HS_LAST));
    assign w_vs_n   = !((r_vcnt >= c_VS_FIRST) && (r_vcnt <= c_VS_LAST));

`ifdef VGA_TEST_PATTERN_EN
    logic w_square;
    logic w_unused_vram;

    assign w_square      = r_col[3] ^ r_row[3];
    assign w_pix_r       = w_square;
    assign w_pix_g       = w_square;
    assign w_pix_b       = !w_square;
    assign w_unused_vram = vram_r ^ vram_g ^ vram_b;
`else
    // The address for the current pixel was issued on the previous tick,
    // so the ROM outputs have been stable for CLK_DIV-1 clocks here.
    assign w_pix_r = vram_r;
    assign w_pix_g = vram_g;
    assign w_pix_b = vram_b;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [13:0] r_vram_addr;
    logic        r_hsync, r_vsync, r_frame_start;
    logic [3:0]  r_vga_r, r_vga_g, r_vga_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hsub        <= '0;
            r_vsub        <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_vram_addr   <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_vga_r       <= 4'h0;
            r_vga_g       <= 4'h0;
            r_vga_b       <= 4'h0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 1'b1;
            // High for the one clk that follows the tick registering (0,0).
            r_frame_start <= w_tick && (r_hcnt == '0) && (r_vcnt == '0);
            if (w_tick) begin
                r_hcnt      <= w_hcnt_nxt;
                r_vcnt      <= w_vcnt_nxt;
                r_hsub      <= w_hsub_nxt;
                r_vsub      <= w_vsub_nxt;
                r_col       <= w_col_nxt;
                r_row       <= w_row_nxt;
                // Address follows the counters so it names the pixel they hold.
                r_vram_addr <= w_active_nxt ? {w_row_nxt[6:0], w_col_nxt[6:0]} : 14'd0;
                r_hsync     <= w_hs_n;
                r_vsync     <= w_vs_n;
                r_vga_r     <= w_active ? {4{w_pix_r}} : 4'h0;
                r_vga_g     <= w_active ? {4{w_pix_g}} : 4'h0;
                r_vga_b     <= w_active ? {4{w_pix_b}} : 4'h0;
            end
        end
    end

    assign vram_addr   = r_vram_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_vram_scanner
// Purpose  : Self-checking bench for vga_vram_scanner. A full-size instance
//            exercises line timing and the scaled image; a reduced-timing
//            instance completes whole frames quickly. A raster-arithmetic
//            model predicts every output on every clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_vram_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [13:0] addr_a, addr_b;
    logic        ram_ra, ram_ga, ram_ba, ram_rb, ram_gb, ram_bb;
    logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int total = 0;
    int bad   = 0;
    int nprint = 0;
    int ka = 0;
    int kb = 0;
    logic chk_en = 1'b0;

    vga_vram_scanner u_big (
        .clk(clk), .reset(rst_a), .vram_addr(addr_a),
        .vram_r(ram_ra), .vram_g(ram_ga), .vram_b(ram_ba),
        .hsync(hs_a), .vsync(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a)
    );

    vga_vram_scanner #(
        .CLK_DIV(2), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(15), .V_FP(2), .V_SYNC(2), .V_BP(3), .SCALE(5)
    ) u_small (
        .clk(clk), .reset(rst_b), .vram_addr(addr_b),
        .vram_r(ram_rb), .vram_g(ram_gb), .vram_b(ram_bb),
        .hsync(hs_b), .vsync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(fs_b)
    );

    // VRAM contents
    function automatic logic rom_r(input logic [13:0] a);
        return (a == 14'd130);
    endfunction
    function automatic logic rom_g(input logic [13:0] a);
        return ((a % 7) == 3);
    endfunction
    function automatic logic rom_b(input logic [13:0] a);
        return a[0] ^ a[5];
    endfunction

    // One-clock-latency ROMs
    always @(posedge clk) begin
        ram_ra <= rom_r(addr_a); ram_ga <= rom_g(addr_a); ram_ba <= rom_b(addr_a);
        ram_rb <= rom_r(addr_b); ram_gb <= rom_g(addr_b); ram_bb <= rom_b(addr_b);
    end

    // Clock edges since reset release (0 while reset is sampled high)
    always @(posedge clk) begin
        ka <= rst_a ? 0 : ka + 1;
        kb <= rst_b ? 0 : kb + 1;
    end

    // Outputs after k edges: {addr, hsync, vsync, r, g, b, frame_start}
    function automatic logic [28:0] model_out(input int k, input int cd,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb, input int sc);
        int ht, vt, fr, t, p, hc, vc;
        logic [13:0] a_now, a_pix;
        logic hs_n, vs_n, act, fs, cr, cg, cb;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        fr = ht * vt;
        t  = k / cd;
        // the address names the pixel at raster position t
        p  = t % fr; hc = p % ht; vc = p / ht;
        a_now = (hc < ha && vc < va) ? 14'((vc / sc) * 128 + hc / sc) : 14'd0;
        if (t == 0) return {a_now, 1'b1, 1'b1, 12'h000, 1'b0};
        // the pins show the pixel one position earlier
        p  = (t - 1) % fr; hc = p % ht; vc = p / ht;
        hs_n  = !(hc >= ha + hf && hc < ha + hf + hs);
        vs_n  = !(vc >= va + vf && vc < va + vf + vs);
        act   = (hc < ha) && (vc < va);
        a_pix = 14'((vc / sc) * 128 + hc / sc);
`ifdef VGA_TEST_PATTERN_EN
        cr = (((hc / sc) / 8) % 2) != (((vc / sc) / 8) % 2);
        cg = cr;
        cb = !cr;
`else
        cr = rom_r(a_pix);
        cg = rom_g(a_pix);
        cb = rom_b(a_pix);
`endif
        if (!act) begin
            cr = 1'b0; cg = 1'b0; cb = 1'b0;
        end
        fs = ((k % cd) == 0) && (((t - 1) % fr) == 0);
        return {a_now, hs_n, vs_n, {4{cr}}, {4{cg}}, {4{cb}}, fs};
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [28:0] exp_a, exp_b, got_a, got_b;
            exp_a = model_out(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33, 5);
            exp_b = model_out(kb, 2, 20, 2, 3, 3, 15, 2, 2, 3, 5);
            got_a = {addr_a, hs_a, vs_a, r_a, g_a, b_a, fs_a};
            got_b = {addr_b, hs_b, vs_b, r_b, g_b, b_b, fs_b};
            total = total + 2;
            if (got_a !== exp_a) begin
                bad = bad + 1;
                if (nprint < 20) $display("FAIL model_big k=%0d got=%h want=%h", ka, got_a, exp_a);
                nprint = nprint + 1;
            end
            if (got_b !== exp_b) begin
                bad = bad + 1;
                if (nprint < 20) $display("FAIL model_small k=%0d got=%h want=%h", kb, got_b, exp_b);
                nprint = nprint + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic wait_ka(input int target);
        int g;
        g = 0;
        while (ka < target && g < 100000) begin @(negedge clk); g++; end
    endtask

    task automatic wait_kb(input int target);
        int g;
        g = 0;
        while (kb < target && g < 100000) begin @(negedge clk); g++; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout got=%0d want=%0d", ka, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (8) @(negedge clk);
        chk("reset_state_big", {addr_a, hs_a, vs_a, r_a, g_a, b_a, fs_a}, {14'd0, 2'b11, 12'h000, 1'b0});
        chk("reset_state_small", {addr_b, hs_b, vs_b, r_b, g_b, b_b, fs_b}, {14'd0, 2'b11, 12'h000, 1'b0});
        rst_a = 1'b0;
        rst_b = 1'b0;

        fork
            begin : th_big
                int k0, gg;
                gg = 0; while (fs_a !== 1'b1 && gg < 20) begin @(negedge clk); gg++; end
                chk("big_first_frame_start", ka, 4);
                gg = 0; while (hs_a !== 1'b0 && gg < 4000) begin @(negedge clk); gg++; end
                chk("big_hsync_fall", ka, 657 * 4);
                k0 = ka;
                gg = 0; while (hs_a !== 1'b1 && gg < 1000) begin @(negedge clk); gg++; end
                chk("big_hsync_low_clks", ka - k0, 384);
                gg = 0; while (hs_a !== 1'b0 && gg < 4000) begin @(negedge clk); gg++; end
                chk("big_line_period", ka - k0, 3200);
                wait_ka(4 * (4 * 800 + 10 + 1));  chk("big_pix_10_4_r", r_a, 0);
                wait_ka(4 * (5 * 800 + 10 + 1));  chk("big_pix_10_5_r", r_a, 15);
                wait_ka(4 * (5 * 800 + 645));     chk("big_addr_blank_645_5", addr_a, 0);
                wait_ka(4 * (7 * 800 + 9 + 1));   chk("big_pix_9_7_r", r_a, 0);
                wait_ka(4 * (7 * 800 + 12));      chk("big_addr_12_7", addr_a, 130);
                wait_ka(4 * (9 * 800 + 14 + 1));  chk("big_pix_14_9_r", r_a, 15);
                wait_ka(4 * (9 * 800 + 15 + 1));  chk("big_pix_15_9_r", r_a, 0);
                wait_ka(4 * (10 * 800 + 10 + 1)); chk("big_pix_10_10_r", r_a, 0);
            end
            begin : th_small
                int k0, gg, n;
                gg = 0; while (fs_b !== 1'b1 && gg < 20) begin @(negedge clk); gg++; end
                chk("small_first_frame_start", kb, 2);
                wait_kb(2 * (14 * 28 + 19));
                chk("small_addr_19_14", addr_b, 259);
                gg = 0; while (vs_b !== 1'b0 && gg < 2000) begin @(negedge clk); gg++; end
                chk("small_vsync_fall", kb, 954);
                k0 = kb;
                gg = 0; while (vs_b !== 1'b1 && gg < 2000) begin @(negedge clk); gg++; end
                chk("small_vsync_low_clks", kb - k0, 112);
                gg = 0; while (fs_b !== 1'b1 && gg < 2000) begin @(negedge clk); gg++; end
                chk("small_frame_period", kb - 2, 1232);
                n = 0;
                repeat (1232) begin @(negedge clk); if (fs_b === 1'b1) n++; end
                chk("small_fs_per_frame", n, 1);
                wait_kb(3000);
                rst_b = 1'b1;
                @(negedge clk);
                chk("small_midreset_state", {addr_b, hs_b, vs_b, r_b, g_b, b_b, fs_b}, {14'd0, 2'b11, 12'h000, 1'b0});
                rst_b = 1'b0;
                gg = 0; while (fs_b !== 1'b1 && gg < 20) begin @(negedge clk); gg++; end
                chk("small_restart_fs", kb, 2);
            end
        join

        // Mid-frame reset of the full-size instance at hcnt=300 of line 10
        wait_ka(4 * (10 * 800 + 300));
        rst_a = 1'b1;
        @(negedge clk);
        chk("big_midreset_state", {addr_a, hs_a, vs_a, r_a, g_a, b_a, fs_a}, {14'd0, 2'b11, 12'h000, 1'b0});
        rst_a = 1'b0;
        g = 0; while (fs_a !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        chk("big_restart_fs", ka, 4);
        repeat (2000) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
